// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU: S1 holds the accepted operation and computes, S2 holds the result bus.
// Optional iterative signed multiplier for opcode 00110 is built only when ALU_MUL_EN is defined.
`timescale 1ns/1ps
module alu_pipe #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   data_operandA,
    input  logic [WIDTH-1:0]   data_operandB,
    input  logic [4:0]         ctrl_ALUopcode,
    input  logic [SHAMT_W-1:0] ctrl_shiftamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   data_result,
    output logic               isNotEqual,
    output logic               isLessThan,
    output logic               overflow
);

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_OR  = 5'b00011;
    localparam logic [4:0] OP_SLL = 5'b00100;
    localparam logic [4:0] OP_SRA = 5'b00101;

    logic               r_s1_valid;
    logic [WIDTH-1:0]   r_s1_a;
    logic [WIDTH-1:0]   r_s1_b;
    logic [4:0]         r_s1_op;
    logic [SHAMT_W-1:0] r_s1_sh;

    logic               r_out_valid;
    logic [WIDTH-1:0]   r_result;
    logic               r_ne;
    logic               r_lt;
    logic               r_ovf;

    logic               w_s2_free;
    logic               w_mul_busy;
    logic               w_s1_adv;
    logic               w_accept;
    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_result;
    logic               w_ovf;

    function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

    function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
        return (sa != sb) && (sr != sa);
    endfunction

    assign w_s2_free = !r_out_valid || out_ready;
    assign w_s1_adv  = r_s1_valid && w_s2_free && !w_mul_busy;
    // Held low during reset so nothing can be accepted before the pipeline is live.
    assign in_ready  = reset_n && (!r_s1_valid || w_s1_adv);
    assign w_accept  = in_valid && in_ready;
    assign w_sum     = r_s1_a + r_s1_b;
    assign w_diff    = r_s1_a - r_s1_b;

`ifdef ALU_MUL_EN
    localparam logic [4:0]         OP_MUL   = 5'b00110;
    localparam logic [SHAMT_W-1:0] CNT_LAST = {SHAMT_W{1'b1}};
    localparam logic [SHAMT_W-1:0] CNT_ONE  = {{(SHAMT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

    mul_state_t         r_mul_state;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [SHAMT_W-1:0] r_mul_cnt;

    assign w_mul_busy = r_s1_valid && (r_s1_op == OP_MUL) && (r_mul_state != MUL_DONE);

    // Shift-add multiplier; the sign bit of B carries negative weight, so it subtracts.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mul_state <= MUL_IDLE;
            r_acc       <= {(2*WIDTH){1'b0}};
            r_mcand     <= {(2*WIDTH){1'b0}};
            r_mplier    <= {WIDTH{1'b0}};
            r_mul_cnt   <= {SHAMT_W{1'b0}};
        end else if (w_accept && (ctrl_ALUopcode == OP_MUL)) begin
            r_mul_state <= MUL_BUSY;
            r_acc       <= {(2*WIDTH){1'b0}};
            r_mcand     <= {{WIDTH{data_operandA[WIDTH-1]}}, data_operandA};
            r_mplier    <= data_operandB;
            r_mul_cnt   <= {SHAMT_W{1'b0}};
        end else begin
            case (r_mul_state)
                MUL_BUSY: begin
                    if (r_mplier[0]) begin
                        if (r_mul_cnt == CNT_LAST) begin
                            r_acc <= r_acc - r_mcand;
                        end else begin
                            r_acc <= r_acc + r_mcand;
                        end
                    end
                    r_mcand   <= {r_mcand[2*WIDTH-2:0], 1'b0};
                    r_mplier  <= {1'b0, r_mplier[WIDTH-1:1]};
                    r_mul_cnt <= r_mul_cnt + CNT_ONE;
                    if (r_mul_cnt == CNT_LAST) begin
                        r_mul_state <= MUL_DONE;
                    end
                end
                MUL_DONE: begin
                    if (w_s1_adv) begin
                        r_mul_state <= MUL_IDLE;
                    end
                end
                MUL_IDLE: begin
                    r_mul_state <= MUL_IDLE;
                end
                default: begin
                    r_mul_state <= MUL_IDLE;
                end
            endcase
        end
    end
`else
    assign w_mul_busy = 1'b0;
`endif

    // Stage S1 result and overflow selection.
    always_comb begin
        w_result = {WIDTH{1'b0}};
        w_ovf    = 1'b0;
        case (r_s1_op)
            OP_ADD: begin
                w_result = w_sum;
                w_ovf    = add_ovf(r_s1_a[WIDTH-1], r_s1_b[WIDTH-1], w_sum[WIDTH-1]);
            end
            OP_SUB: begin
                w_result = w_diff;
                w_ovf    = sub_ovf(r_s1_a[WIDTH-1], r_s1_b[WIDTH-1], w_diff[WIDTH-1]);
            end
            OP_AND:  w_result = r_s1_a & r_s1_b;
            OP_OR:   w_result = r_s1_a | r_s1_b;
            OP_SLL:  w_result = r_s1_a << r_s1_sh;
            OP_SRA:  w_result = $signed(r_s1_a) >>> r_s1_sh;
`ifdef ALU_MUL_EN
            OP_MUL: begin
                w_result = r_acc[WIDTH-1:0];
                w_ovf    = (r_acc[2*WIDTH-1:WIDTH] != {WIDTH{r_acc[WIDTH-1]}});
            end
`endif
            default: begin
                w_result = {WIDTH{1'b0}};
                w_ovf    = 1'b0;
            end
        endcase
    end

    // Stage S1 operation capture.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= {WIDTH{1'b0}};
            r_s1_b     <= {WIDTH{1'b0}};
            r_s1_op    <= 5'b00000;
            r_s1_sh    <= {SHAMT_W{1'b0}};
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_a     <= data_operandA;
            r_s1_b     <= data_operandB;
            r_s1_op    <= ctrl_ALUopcode;
            r_s1_sh    <= ctrl_shiftamt;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage S2 result bus; holds steady while downstream stalls.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_result    <= {WIDTH{1'b0}};
            r_ne        <= 1'b0;
            r_lt        <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_s1_adv) begin
            r_out_valid <= 1'b1;
            r_result    <= w_result;
            r_ne        <= (r_s1_a != r_s1_b);
            r_lt        <= ($signed(r_s1_a) < $signed(r_s1_b));
            r_ovf       <= w_ovf;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid   = r_out_valid;
    assign data_result = r_result;
    assign isNotEqual  = r_ne;
    assign isLessThan  = r_lt;
    assign overflow    = r_ovf;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed vectors with literal expectations plus a
// signed-arithmetic reference model and in-order scoreboard checked every cycle.
`timescale 1ns/1ps
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  opcode;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_result;
    logic        isNotEqual;
    logic        isLessThan;
    logic        overflow;

    int total = 0;
    int bad   = 0;
    int last_waits;

    typedef struct packed {
        logic [31:0] r;
        logic        o;
        logic        n;
        logic        l;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    logic        held_v;
    logic [34:0] held;

    alu_pipe #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clock          (clk),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .data_operandA  (op_a),
        .data_operandB  (op_b),
        .ctrl_ALUopcode (opcode),
        .ctrl_shiftamt  (shamt),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .data_result    (data_result),
        .isNotEqual     (isNotEqual),
        .isLessThan     (isLessThan),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: exact signed arithmetic on 64-bit integers.
    function automatic exp_t model(input logic [4:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] sh);
        longint sa, sb, p;
        longint maxv, minv;
        exp_t   e;
        maxv = 64'sd2147483647;
        minv = -64'sd2147483648;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.n = (a != b);
        e.l = (sa < sb);
        e.o = 1'b0;
        e.r = 32'h0;
        case (op)
            5'd0: begin p = sa + sb; e.r = p[31:0]; e.o = (p > maxv) || (p < minv); end
            5'd1: begin p = sa - sb; e.r = p[31:0]; e.o = (p > maxv) || (p < minv); end
            5'd2: e.r = a & b;
            5'd3: e.r = a | b;
            5'd4: e.r = a << sh;
            5'd5: begin p = sa >>> sh; e.r = p[31:0]; end
`ifdef ALU_MUL_EN
            5'd6: begin p = sa * sb; e.r = p[31:0]; e.o = (p > maxv) || (p < minv); end
`endif
            default: e.r = 32'h0;
        endcase
        return e;
    endfunction

    // Scoreboard: push on accept, compare on transfer, check stability while stalled.
    initial begin
        held_v = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                q.delete();
                held_v = 1'b0;
            end else begin
                if (held_v) begin
                    chk("hold stable", {out_valid, data_result, overflow, isNotEqual, isLessThan},
                        {1'b1, held});
                end
                held_v = 1'b0;
                if (out_valid) begin
                    if (q.size() == 0) begin
                        chk("spurious out_valid", {63'd0, out_valid}, 64'd0);
                    end else if (out_ready) begin
                        mon_e = q.pop_front();
                        chk("scoreboard", {data_result, overflow, isNotEqual, isLessThan},
                            {mon_e.r, mon_e.o, mon_e.n, mon_e.l});
                    end else begin
                        held   = {data_result, overflow, isNotEqual, isLessThan};
                        held_v = 1'b1;
                    end
                end
                if (in_valid && in_ready) begin
                    q.push_back(model(opcode, op_a, op_b, shamt));
                end
            end
        end
    end

    // Present an operation and wait (bounded) for it to be accepted; leaves in_valid high.
    task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh);
        int n;
        opcode   = op;
        op_a     = a;
        op_b     = b;
        shamt    = sh;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        last_waits = n;
        if (!in_ready) begin
            chk("accept timeout", {63'd0, in_ready}, 64'd1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run1(input string nm, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh, input logic [31:0] er,
                        input logic eo, input logic en, input logic el, input int elat);
        exp_t m;
        int   lat;
        m = model(op, a, b, sh);
        chk({nm, " model"}, {29'd0, m.r, m.o, m.n, m.l}, {29'd0, er, eo, en, el});
        out_ready = 1'b1;
        send(op, a, b, sh);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({nm, " latency"}, lat, elat);
        chk({nm, " result"}, {29'd0, data_result, overflow, isNotEqual, isLessThan},
            {29'd0, er, eo, en, el});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int   seen;
        logic done;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op_a      = 32'h0;
        op_b      = 32'h0;
        opcode    = 5'd0;
        shamt     = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", {63'd0, in_ready}, 64'd0);
        chk("reset outputs", {29'd0, out_valid, data_result, overflow, isNotEqual, isLessThan},
            64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready after release", {63'd0, in_ready}, 64'd1);

        run1("add ovf",   5'd0, 32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b1, 1'b1, 1'b0, 2);
        run1("sub neg",   5'd1, 32'h00000003, 32'h00000005, 5'd0,  32'hFFFFFFFE, 1'b0, 1'b1, 1'b1, 2);
        run1("sub ovf",   5'd1, 32'h80000000, 32'h00000001, 5'd0,  32'h7FFFFFFF, 1'b1, 1'b1, 1'b1, 2);
        run1("sub lt",    5'd1, 32'h80000000, 32'h7FFFFFFF, 5'd0,  32'h00000001, 1'b1, 1'b1, 1'b1, 2);
        run1("sll 31",    5'd4, 32'h00000001, 32'h00000000, 5'd31, 32'h80000000, 1'b0, 1'b1, 1'b0, 2);
        run1("sra 4",     5'd5, 32'h80000000, 32'h00000000, 5'd4,  32'hF8000000, 1'b0, 1'b1, 1'b1, 2);
        run1("sra 31",    5'd5, 32'h7FFFFFFF, 32'h00000000, 5'd31, 32'h00000000, 1'b0, 1'b1, 1'b0, 2);
        run1("or",        5'd3, 32'hF0F0F0F0, 32'h0F0F0F0F, 5'd0,  32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 2);
        run1("and",       5'd2, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000, 1'b0, 1'b1, 1'b1, 2);
        run1("sll 0",     5'd4, 32'h12345678, 32'h12345678, 5'd0,  32'h12345678, 1'b0, 1'b0, 1'b0, 2);
        run1("undef 1f",  5'd31, 32'h00000005, 32'h00000005, 5'd3, 32'h00000000, 1'b0, 1'b0, 1'b0, 2);
        run1("undef 07",  5'd7, 32'h00000009, 32'h00000002, 5'd1,  32'h00000000, 1'b0, 1'b1, 1'b0, 2);
`ifdef ALU_MUL_EN
        run1("mul neg",   5'd6, 32'hFFFFFFFD, 32'h00000007, 5'd0,  32'hFFFFFFEB, 1'b0, 1'b1, 1'b1, 34);
        run1("mul ovf",   5'd6, 32'h00010000, 32'h00010000, 5'd0,  32'h00000000, 1'b1, 1'b0, 1'b0, 34);
`else
        run1("mul off",   5'd6, 32'hFFFFFFFD, 32'h00000007, 5'd0,  32'h00000000, 1'b0, 1'b1, 1'b1, 2);
        run1("mul off2",  5'd6, 32'h00010000, 32'h00010000, 5'd0,  32'h00000000, 1'b0, 1'b0, 1'b0, 2);
`endif

        // Back-to-back with a stalled consumer: two accepts fill the pipe.
        out_ready = 1'b0;
        send(5'd0, 32'd1, 32'd1, 5'd0);
        send(5'd0, 32'd2, 32'd2, 5'd0);
        opcode = 5'd0;
        op_a   = 32'd3;
        op_b   = 32'd3;
        repeat (3) begin
            @(negedge clk);
            chk("b2b in_ready low", {63'd0, in_ready}, 64'd0);
            chk("b2b held result", {32'd0, data_result}, 64'd2);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        chk("b2b first", {31'd0, out_valid, data_result}, {31'd0, 1'b1, 32'd2});
        send(5'd0, 32'd3, 32'd3, 5'd0);
        in_valid = 1'b0;
        chk("b2b second", {31'd0, out_valid, data_result}, {31'd0, 1'b1, 32'd4});
        @(posedge clk);
        #1;
        chk("b2b third", {31'd0, out_valid, data_result}, {31'd0, 1'b1, 32'd6});
        @(posedge clk);
        #1;
        chk("b2b drained", {63'd0, out_valid}, 64'd0);

        // Full throughput with out_ready held high.
        for (int i = 0; i < 8; i++) begin
            send(5'(i % 6), 32'h11111111 * 32'(i + 1), 32'h0F0F0F0F ^ 32'(i * 7), 5'(i * 5));
            if (i > 0) chk("throughput", last_waits, 0);
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Random backpressure; scoreboard covers ordering and stability.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    send(5'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom_range(0, 31)));
                end
                in_valid = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("all results delivered", q.size(), 0);

        // Reset ten cycles into a multiply with the consumer stalled.
        out_ready = 1'b0;
        send(5'd6, 32'hFFFFFFFD, 32'h00000007, 5'd0);
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid-op reset outputs", {29'd0, out_valid, data_result, overflow, isNotEqual, isLessThan},
            64'd0);
        chk("mid-op reset in_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready after mid-op reset", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("no stale result", seen, 0);
        run1("post reset add", 5'd0, 32'd10, 32'hFFFFFFFF, 5'd0, 32'd9, 1'b0, 1'b1, 1'b0, 2);

        chk("scoreboard empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
